// File: rtl/seq_counter_pkg.sv
// seq_counter_pkg: shared constants and helpers for the programmable-sequence counter.
// Provides direction/mode encodings and the entry-count clamp used by the top level.
// No ports; imported by seq_counter and seq_table.
package seq_counter_pkg;

  localparam logic DIR_FWD      = 1'b0;
  localparam logic DIR_BWD      = 1'b1;
  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  // Effective entry count: a zero length still means one entry, and the
  // length can never exceed the physical table depth.
  function automatic int unsigned len_clamp(input int unsigned len,
                                            input int unsigned depth);
    if (len == 0)    return 1;
    if (len > depth) return depth;
    return len;
  endfunction

endpackage

// File: rtl/seq_table.sv
// seq_table: DEPTH x WIDTH register file holding the counter's sequence values.
// Ports: clk/reset_n; write port wr_en/wr_addr/wr_data (synchronous);
//        read port rd_addr -> rd_data (combinational). Reset loads table[i] = i.
module seq_table
  import seq_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             addr_ok;

  // Only a non-power-of-two depth leaves addresses that map to no entry.
  if (DEPTH == (1 << IW)) begin : g_full
    assign addr_ok = 1'b1;
  end else begin : g_partial
    assign addr_ok = (32'(wr_addr) < DEPTH);
  end

  // Identity init makes the default table behave as a plain binary counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= WIDTH'(i);
    end else if (wr_en && addr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/seq_counter.sv
// seq_counter: steps an index through a programmable value table, forward or
// backward, wrapping or stopping at the terminal entry.
// Ports: clk, reset_n, en, clr, dir, one_shot, len, wr_en/wr_addr/wr_data in;
//        num (table value at idx), idx, tc (one-cycle terminal pulse), done out.
module seq_counter
  import seq_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int IW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic             dir,
  input  logic             one_shot,
  input  logic [LW-1:0]    len,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] num,
  output logic [IW-1:0]    idx,
  output logic             tc,
  output logic             done
);

  logic [IW-1:0] idx_q, idx_nxt;
  logic          tc_q, tc_nxt;
  logic          done_q, done_nxt;
  int unsigned   len_eff;
  int unsigned   cur;
  int unsigned   start_i;
  logic          at_term;

  always_comb begin
    len_eff  = len_clamp(32'(len), DEPTH);
    cur      = 32'(idx_q);
    start_i  = (dir == DIR_BWD) ? (len_eff - 1) : 0;

    // An index left beyond the active length (len shrunk mid-run) counts as
    // terminal in either direction, so it re-enters the valid range next step.
    if (cur >= len_eff)      at_term = 1'b1;
    else if (dir == DIR_BWD) at_term = (cur == 0);
    else                     at_term = (cur == len_eff - 1);

    idx_nxt  = idx_q;
    tc_nxt   = 1'b0;
    done_nxt = done_q;

    if (clr) begin
      idx_nxt  = IW'(start_i);
      done_nxt = 1'b0;
    end else if (en && !done_q) begin
      if (!at_term) begin
        idx_nxt = (dir == DIR_BWD) ? (idx_q - IW'(1)) : (idx_q + IW'(1));
      end else begin
        tc_nxt = 1'b1;
        if (one_shot == MODE_ONESHOT) done_nxt = 1'b1;
        else                          idx_nxt  = IW'(start_i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q  <= '0;
      tc_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_nxt;
      tc_q   <= tc_nxt;
      done_q <= done_nxt;
    end
  end

  seq_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_table (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_q),
    .rd_data (num)
  );

  assign idx  = idx_q;
  assign tc   = tc_q;
  assign done = done_q;

endmodule

// File: doc/seq_counter.md
# seq_counter

Parametrised arbitrary-sequence counter: steps through a run-time programmable table of up to DEPTH values of WIDTH bits, forward or backward, in wrap or one-shot mode. Replaces fixed-sequence 3-bit FSM counters (dice rollers, custom step patterns) with one reusable block. Sits beside display and timing logic as a pattern source, with a terminal-count pulse for cascading.

## Interface
- WIDTH, 4, bit width of each sequence value and of `num`
- DEPTH, 8, maximum table entries (≥2); IW = $clog2(DEPTH), LW = $clog2(DEPTH+1)
- clk  input  1  clock, rising edge
- reset_n  input  1  reset, asynchronous, active-low
- en  input  1  advance one step per cycle when high
- clr  input  1  synchronous restart to start index; clears `done`
- dir  input  1  0 = forward (index up), 1 = backward (index down)
- one_shot  input  1  0 = wrap at terminal, 1 = stop at terminal
- len  input  LW  active entry count; 0 is treated as 1, values >DEPTH as DEPTH (len_eff)
- wr_en  input  1  table write strobe
- wr_addr  input  IW  table entry to write
- wr_data  input  WIDTH  value written
- num  output  WIDTH  current value, table[idx]
- idx  output  IW  current table index
- tc  output  1  registered one-cycle terminal-count pulse
- done  output  1  one-shot finished, held until clr/reset

## Operation
- Reset: idx=0, done=0, tc=0, table[i] = i mod 2^WIDTH. With len=DEPTH, forward, wrap, the block is a plain binary counter.
- Terminal index: forward → len_eff-1; backward → 0. Any idx ≥ len_eff (len reduced mid-run) is also terminal.
- Start index: forward → 0; backward → len_eff-1.
- Per cycle, priority clr > en:
  - clr=1: idx←start index, done←0, tc←0.
  - en=1, done=0, idx not terminal: idx←idx±1, tc←0.
  - en=1, done=0, idx terminal, one_shot=0: idx←start index, tc←1.
  - en=1, done=0, idx terminal, one_shot=1: idx unchanged, done←1, tc←1.
  - en=1, done=1: no change, tc←0.
  - en=0: idx held, tc←0.
- dir or one_shot changes take effect on the next step; no restart implied.
- Table writes are independent of stepping and clr. A write to an entry, including the current idx, is visible on `num` after the writing edge. A write with wr_addr ≥ DEPTH is ignored.
- `num` is a combinational read of table[idx]. With idx ≥ DEPTH it cannot occur; with idx ≥ len_eff it still shows table[idx] until the next step.

## Timing
- Step latency: `idx`/`num` update on the edge at which en=1 is sampled.
- `tc`/`done` assert on the same edge as the terminal step. `tc` is high for exactly one cycle unless en remains high across consecutive wraps; with len_eff=1 in wrap mode, tc is high every enabled cycle.
- clr and en both high: clr wins and tc=0.
- Async reset mid-run: all state, including the table, returns to reset values immediately. Outputs are valid the first edge after deassertion.

## Structure
- Package `seq_counter_pkg`: `DIR_FWD`/`DIR_BWD` and `MODE_WRAP`/`MODE_ONESHOT` constants; function `len_clamp(len, DEPTH)` returning len_eff.
- Sub-module `seq_table`: DEPTH×WIDTH register file with one synchronous write port, one asynchronous read port, and identity reset init. Parameters WIDTH and DEPTH.
- Top: index register, done/tc flags, next-index logic in one always_comb.

## Test plan
- Default table, len=8, forward, wrap, en=1 for 10 cycles → num 0..7,0,1; tc high only in the cycle after 7→0.
- Program 6 entries {1,6,2,3,4,5}, len=6, wrap → num repeats 1,6,2,3,4,5,1; tc pulses once per 6 steps.
- Same table, dir=1, one_shot=1 → after clr: 5,4,3,2,6,1; next en sets done=1 and tc=1 for one cycle; num holds 1 with further en; clr → num=5, done=0.
- len=8 running at idx=6, change len to 4 → next en: idx wraps to 0 with tc=1. len=0 → idx stays 0 and tc=1 on every enabled cycle.
- clr and en together at idx=3 → idx=0, tc=0. Write table[idx] while en=0 → num shows new value next cycle.
- Assert reset_n mid-sequence after table programming → idx=0, done=0, tc=0, table back to identity (num=0); counting resumes from 0 after release.
